// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: streams 16-bit words from instruction memory into a small FIFO
// and presents assembled 16/32-bit instructions to the decoder over a valid/ready handshake.
module prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [19:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [19:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [19:0] instr_pc,
  output logic        instr_long
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne = 1;
  localparam logic [PW-1:0] PtrTwo = 2;

  logic [15:0]   word_q [DEPTH];
  logic [15:0]   word_d [DEPTH];
  logic [19:0]   pc_q   [DEPTH];
  logic [19:0]   pc_d   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          inflight_q, inflight_d;
  logic [19:0]   inflight_pc_q, inflight_pc_d;
  logic [19:0]   fetch_pc_q, fetch_pc_d;

  logic [PW-1:0] count;
  logic [AW-1:0] head_idx, second_idx;
  logic [PW-1:0] rd_plus1;
  logic [15:0]   head_word, second_word;
  logic          head_long, valid_raw, fire, push, space;

  always_comb begin
    count       = wr_ptr_q - rd_ptr_q;
    rd_plus1    = rd_ptr_q + PtrOne;
    head_idx    = rd_ptr_q[AW-1:0];
    second_idx  = rd_plus1[AW-1:0];
    head_word   = word_q[head_idx];
    second_word = word_q[second_idx];
    head_long   = head_word[15];
    // A long head needs its second half buffered before it is presented.
    valid_raw   = head_long ? (count >= PtrTwo) : (count != '0);
    // Occupancy is taken before this cycle's pop, so a read always has a free slot.
    space       = (int'(count) + int'(inflight_q)) < int'(DEPTH);
  end

  always_comb begin
    imem_req    = !reset && !redirect_valid && space;
    imem_addr   = reset ? 20'h00000 : fetch_pc_q;
    instr_valid = !reset && valid_raw;
    instr_long  = !reset && head_long;
    instr_pc    = reset ? 20'h00000 : pc_q[head_idx];
    instr_data  = 32'h0;
    if (instr_valid) begin
      instr_data = head_long ? {second_word, head_word} : {16'h0000, head_word};
    end
  end

  always_comb begin
    fire          = instr_valid && instr_ready;
    push          = inflight_q && !redirect_valid;
    word_d        = word_q;
    pc_d          = pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    fetch_pc_d    = fetch_pc_q;

    if (push) begin
      word_d[wr_ptr_q[AW-1:0]] = imem_data;
      pc_d[wr_ptr_q[AW-1:0]]   = inflight_pc_q;
      wr_ptr_d                 = wr_ptr_q + PtrOne;
      inflight_d               = 1'b0;
    end
    if (fire) begin
      rd_ptr_d = rd_ptr_q + (head_long ? PtrTwo : PtrOne);
    end
    if (imem_req) begin
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
      fetch_pc_d    = fetch_pc_q + 20'd1;
    end
    // Redirect discards buffered and returning words; a same-cycle handshake already happened.
    if (redirect_valid) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        word_q[i] <= 16'h0000;
        pc_q[i]   <= 20'h00000;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 20'h00000;
      fetch_pc_q    <= RESET_PC;
    end else begin
      word_q        <= word_d;
      pc_q          <= pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_pc_q    <= fetch_pc_d;
    end
  end

endmodule
